dmem_responder: RTL and testbench



---
 rtl/otter_mem_pkg.sv | 68 ++++++
 rtl/dmem_bank.sv | 26 ++
 rtl/dmem_responder.sv | 160 ++++++++++++++++
 tb/tb_dmem_responder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_mem_pkg.sv
// rtl/otter_mem_pkg.sv - shared types and helpers for the OTTER data-memory responder
package otter_mem_pkg;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h1100_0000;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } mem_size_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } state_e;

  // Which registered source feeds the load-result extender.
  typedef enum logic [1:0] {
    SRC_ZERO  = 2'd0,
    SRC_RAM   = 2'd1,
    SRC_IO    = 2'd2,
    SRC_MERGE = 2'd3
  } dout_src_e;

  // Lane mask for an access starting at lane 0; zero for unused funct3 codes.
  function automatic logic [3:0] size_mask(input logic [2:0] size);
    logic [3:0] m;
    case (size)
      SZ_B, SZ_BU: m = 4'b0001;
      SZ_H, SZ_HU: m = 4'b0011;
      SZ_W:        m = 4'b1111;
      default:     m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic size_legal(input logic [2:0] size);
    return size_mask(size) != 4'b0000;
  endfunction

  // True when the access runs past lane 3 into the next word.
  function automatic logic is_crossing(input logic [2:0] size, input logic [1:0] lane);
    logic c;
    case (size)
      SZ_H, SZ_HU: c = (lane == 2'd3);
      SZ_W:        c = (lane != 2'd0);
      default:     c = 1'b0;
    endcase
    return c;
  endfunction

  // Sign/zero extension of right-aligned load bytes.
  function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [2:0] size);
    logic [31:0] r;
    case (size)
      SZ_B:    r = {{24{raw[7]}}, raw[7:0]};
      SZ_H:    r = {{16{raw[15]}}, raw[15:0]};
      SZ_W:    r = raw;
      SZ_BU:   r = {24'h0, raw[7:0]};
      SZ_HU:   r = {16'h0, raw[15:0]};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// rtl/dmem_bank.sv - four byte-lane RAM with per-lane write enables and synchronous read
module dmem_bank #(
  parameter int DEPTH_WORDS = 16384
) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [3:0]                     we,
  input  logic [31:0]                    wdata,
  input  logic                           re,
  output logic [31:0]                    rdata
);

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] lane_mem [DEPTH_WORDS];
    logic [7:0] rd_q;

    // Per-lane write and read; read data only moves when re is set so it holds between loads.
    always_ff @(posedge clk) begin
      if (we[g]) lane_mem[addr] <= wdata[8*g +: 8];
      if (re) rd_q <= lane_mem[addr];
    end

    assign rdata[8*g +: 8] = rd_q;
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - OTTER memory-stage port 2 responder: lane steering, split accesses, IO decode
module dmem_responder
  import otter_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 16384,
  parameter logic [31:0] IO_BASE     = IO_BASE_DEFAULT
) (
  input  logic        MEM_CLOCK,
  input  logic        MEM_RESET,
  input  logic [31:0] MEM_ADDR2,
  input  logic [31:0] MEM_DIN2,
  input  logic        MEM_WE2,
  input  logic        MEM_RDEN2,
  input  logic [2:0]  MEM_SIZE,
  input  logic [31:0] IOBUS_IN,
  output logic        IO_WR,
  output logic        MEM_STALL,
  output logic [31:0] MEM_DOUT2,
  output logic        MEM_VALID2
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e      state_q, state_d;
  dout_src_e   src_q, src_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] io_q, io_d;
  logic [23:0] cap_q, cap_d;
  logic        valid_q, valid_d;

  logic [1:0]    lane;
  logic [AW-1:0] word_idx;
  logic          is_io, legal, idle, req, is_load, crossing;
  logic [63:0]   wide_data;
  logic [7:0]    wide_be;
  logic [31:0]   first_bytes;

  logic [AW-1:0] bank_addr;
  logic [3:0]    bank_we;
  logic [31:0]   bank_wdata;
  logic          bank_re;
  logic [31:0]   bank_rdata;

  assign lane      = MEM_ADDR2[1:0];
  assign word_idx  = MEM_ADDR2[2 +: AW];
  assign is_io     = (MEM_ADDR2 >= IO_BASE);
  assign legal     = size_legal(MEM_SIZE);
  assign idle      = (state_q == ST_IDLE);
  assign req       = MEM_WE2 | MEM_RDEN2;
  assign is_load   = MEM_RDEN2 & ~MEM_WE2;
  assign crossing  = legal & ~is_io & is_crossing(MEM_SIZE, lane);
  // Low word carries the first-word lanes, high word the spill-over into word+1.
  assign wide_data = {32'h0, MEM_DIN2} << {lane, 3'b000};
  assign wide_be   = {4'h0, size_mask(MEM_SIZE)} << lane;

  assign MEM_STALL  = idle & req & crossing;
  assign IO_WR      = idle & MEM_WE2 & is_io & legal;
  assign MEM_VALID2 = valid_q;

  // Bank port steering: IDLE touches the addressed word, SPLIT the following (wrapping) word.
  always_comb begin
    bank_addr  = word_idx;
    bank_we    = 4'h0;
    bank_wdata = wide_data[31:0];
    bank_re    = 1'b0;
    if (idle) begin
      if (MEM_WE2 && legal && !is_io) bank_we = wide_be[3:0];
      bank_re = is_load & legal & ~is_io;
    end else begin
      bank_addr  = word_idx + AW'(1);
      bank_wdata = wide_data[63:32];
      if (MEM_WE2 && !MEM_RESET) bank_we = wide_be[7:4];
      bank_re = is_load;
    end
  end

  dmem_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank (
    .clk   (MEM_CLOCK),
    .addr  (bank_addr),
    .we    (bank_we),
    .wdata (bank_wdata),
    .re    (bank_re),
    .rdata (bank_rdata)
  );

  assign first_bytes = bank_rdata >> {lane_q, 3'b000};

  // Next-state: FSM transitions, load bookkeeping and the capture of first-word bytes.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    size_d  = size_q;
    lane_d  = lane_q;
    io_d    = io_q;
    cap_d   = cap_q;
    valid_d = 1'b0;
    if (idle) begin
      if (req && crossing) state_d = ST_SPLIT;
      if (is_load) begin
        size_d = MEM_SIZE;
        lane_d = lane;
        if (!legal) begin
          src_d   = SRC_ZERO;
          valid_d = 1'b1;
        end else if (is_io) begin
          src_d   = SRC_IO;
          io_d    = IOBUS_IN;
          valid_d = 1'b1;
        end else if (!crossing) begin
          src_d   = SRC_RAM;
          valid_d = 1'b1;
        end
      end
    end else begin
      state_d = ST_IDLE;
      if (is_load) begin
        cap_d   = first_bytes[23:0];
        src_d   = SRC_MERGE;
        valid_d = 1'b1;
      end
    end
  end

  // State registers; reset abandons any split in progress and clears the load result.
  always_ff @(posedge MEM_CLOCK) begin
    if (MEM_RESET) begin
      state_q <= ST_IDLE;
      src_q   <= SRC_ZERO;
      size_q  <= 3'b000;
      lane_q  <= 2'b00;
      io_q    <= 32'h0;
      cap_q   <= 24'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      size_q  <= size_d;
      lane_q  <= lane_d;
      io_q    <= io_d;
      cap_q   <= cap_d;
      valid_q <= valid_d;
    end
  end

  // Load result from registered sources only; second-word bytes sit above the captured ones.
  always_comb begin
    logic [31:0] raw;
    logic [31:0] merged;
    merged = (bank_rdata << {3'd4 - {1'b0, lane_q}, 3'b000}) | {8'h0, cap_q};
    case (src_q)
      SRC_RAM:   raw = first_bytes;
      SRC_IO:    raw = io_q;
      SRC_MERGE: raw = merged;
      default:   raw = 32'h0;
    endcase
    MEM_DOUT2 = extend_load(raw, size_q);
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder against a byte-linear memory model
module tb_dmem_responder;

  localparam int          DEPTH  = 16384;
  localparam int          NBYTES = DEPTH * 4;
  localparam logic [31:0] IOB    = 32'h1100_0000;

  logic        clk = 1'b0;
  logic        rst, we, rd;
  logic [31:0] addr, din, iobus;
  logic [2:0]  size;
  logic        io_wr, stall, valid;
  logic [31:0] dout;

  int tests = 0;
  int fails = 0;

  logic [7:0] model [NBYTES];

  logic        s0, s1, vm, v, iw;
  logic [31:0] q;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .IO_BASE(IOB)) dut (
    .MEM_CLOCK  (clk),
    .MEM_RESET  (rst),
    .MEM_ADDR2  (addr),
    .MEM_DIN2   (din),
    .MEM_WE2    (we),
    .MEM_RDEN2  (rd),
    .MEM_SIZE   (size),
    .IOBUS_IN   (iobus),
    .IO_WR      (io_wr),
    .MEM_STALL  (stall),
    .MEM_DOUT2  (dout),
    .MEM_VALID2 (valid)
  );

  always #5 clk = ~clk;

  function automatic int nbytes_of(input logic [2:0] s);
    case (s)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic [31:0] ext(input logic [31:0] raw, input logic [2:0] s);
    int    n;
    longint val;
    n = nbytes_of(s);
    if (n == 0) return 32'h0;
    if (n == 4) return raw;
    val = longint'(raw) % (64'd1 << (8 * n));
    if (s[2] == 1'b0 && val >= longint'(64'd1 << (8 * n - 1))) val = val - longint'(64'd1 << (8 * n));
    return val[31:0];
  endfunction

  function automatic bit will_split(input logic [31:0] a, input logic [2:0] s);
    int n;
    n = nbytes_of(s);
    return (n != 0) && (a < IOB) && ((int'(a % 4) + n) > 4);
  endfunction

  function automatic void model_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s, input int limit);
    int n;
    n = nbytes_of(s);
    if (a >= IOB) return;
    for (int i = 0; i < n && i < limit; i++) model[(a + i) % NBYTES] = 8'((d >> (8 * i)) & 32'hFF);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] s, input logic [31:0] io);
    logic [31:0] raw;
    int n;
    n = nbytes_of(s);
    if (n == 0) return 32'h0;
    if (a >= IOB) return ext(io, s);
    raw = 32'h0;
    for (int i = 0; i < n; i++) raw = raw | (32'(model[(a + i) % NBYTES]) << (8 * i));
    return ext(raw, s);
  endfunction

  task automatic drive_req(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] s, output logic st0, output logic st1, output logic vmid,
                           output logic vo, output logic [31:0] qo, output logic iow);
    @(negedge clk);
    we = w; rd = r; addr = a; din = d; size = s;
    #1;
    st0 = stall;
    iow = io_wr;
    @(posedge clk); #1;
    st1  = stall;
    vmid = valid;
    if (st0) begin
      @(posedge clk); #1;
    end
    we = 1'b0; rd = 1'b0;
    vo = valid;
    qo = dout;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
    drive_req(1'b1, 1'b0, a, d, s, s0, s1, vm, v, q, iw);
    model_store(a, d, s, 4);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (dout !== 32'h0)  begin fails++; $display("FAIL reset_dout got %h exp 00000000", dout); end
    tests++; if (valid !== 1'b0)  begin fails++; $display("FAIL reset_valid got %b exp 0", valid); end
    tests++; if (stall !== 1'b0)  begin fails++; $display("FAIL reset_stall got %b exp 0", stall); end
    tests++; if (io_wr !== 1'b0)  begin fails++; $display("FAIL reset_io_wr got %b exp 0", io_wr); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_word();
    logic [31:0] hold;
    store(32'h100, 32'hDEADBEEF, 3'b010);
    tests++; if (v !== 1'b0) begin fails++; $display("FAIL sw_valid got %b exp 0", v); end
    drive_req(1'b0, 1'b1, 32'h100, 32'h0, 3'b010, s0, s1, vm, v, q, iw);
    tests++; if (v !== 1'b1) begin fails++; $display("FAIL lw_valid got %b exp 1", v); end
    tests++; if (q !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_data got %h exp deadbeef", q); end
    hold = q;
    @(posedge clk); #1;
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL valid_pulse got %b exp 0", valid); end
    tests++; if (dout !== hold) begin fails++; $display("FAIL dout_hold got %h exp %h", dout, hold); end
  endtask

  task automatic test_byte();
    store(32'h101, 32'h0000_0080, 3'b000);
    drive_req(1'b0, 1'b1, 32'h101, 32'h0, 3'b000, s0, s1, vm, v, q, iw);
    tests++; if (q !== 32'hFFFFFF80) begin fails++; $display("FAIL lb got %h exp ffffff80", q); end
    drive_req(1'b0, 1'b1, 32'h101, 32'h0, 3'b100, s0, s1, vm, v, q, iw);
    tests++; if (q !== 32'h00000080) begin fails++; $display("FAIL lbu got %h exp 00000080", q); end
    drive_req(1'b0, 1'b1, 32'h100, 32'h0, 3'b010, s0, s1, vm, v, q, iw);
    tests++; if (q !== 32'hDEAD80EF) begin fails++; $display("FAIL lw_after_sb got %h exp dead80ef", q); end
    drive_req(1'b0, 1'b1, 32'h102, 32'h0, 3'b001, s0, s1, vm, v, q, iw);
    tests++; if (q !== model_load(32'h102, 3'b001, 32'h0)) begin fails++; $display("FAIL lh_lane2 got %h exp %h", q, model_load(32'h102, 3'b001, 32'h0)); end
  endtask

  task automatic test_split();
    store(32'h200, 32'h0, 3'b010);
    store(32'h204, 32'h0, 3'b010);
    store(32'h203, 32'h11223344, 3'b010);
    tests++; if (s0 !== 1'b1) begin fails++; $display("FAIL split_stall got %b exp 1", s0); end
    tests++; if (s1 !== 1'b0) begin fails++; $display("FAIL split_stall_drop got %b exp 0", s1); end
    drive_req(1'b0, 1'b1, 32'h200, 32'h0, 3'b010, s0, s1, vm, v, q, iw);
    tests++; if (q !== 32'h44000000) begin fails++; $display("FAIL split_lo_word got %h exp 44000000", q); end
    drive_req(1'b0, 1'b1, 32'h204, 32'h0, 3'b010, s0, s1, vm, v, q, iw);
    tests++; if (q !== 32'h00112233) begin fails++; $display("FAIL split_hi_word got %h exp 00112233", q); end
    drive_req(1'b0, 1'b1, 32'h203, 32'h0, 3'b010, s0, s1, vm, v, q, iw);
    tests++; if (vm !== 1'b0) begin fails++; $display("FAIL split_valid_early got %b exp 0", vm); end
    tests++; if (v !== 1'b1 || q !== 32'h11223344) begin fails++; $display("FAIL split_load got v=%b %h exp v=1 11223344", v, q); end
  endtask

  task automatic test_io();
    store(32'h0, 32'h0BADF00D, 3'b010);
    drive_req(1'b1, 1'b0, IOB, 32'hCAFE0001, 3'b010, s0, s1, vm, v, q, iw);
    tests++; if (iw !== 1'b1 || s0 !== 1'b0) begin fails++; $display("FAIL io_store got io_wr=%b stall=%b exp 1 0", iw, s0); end
    drive_req(1'b0, 1'b1, 32'h0, 32'h0, 3'b010, s0, s1, vm, v, q, iw);
    tests++; if (q !== 32'h0BADF00D) begin fails++; $display("FAIL io_ram_untouched got %h exp 0badf00d", q); end
    iobus = 32'h0000F00D;
    drive_req(1'b0, 1'b1, IOB, 32'h0, 3'b001, s0, s1, vm, v, q, iw);
    tests++; if (v !== 1'b1 || q !== 32'hFFFFF00D) begin fails++; $display("FAIL io_lh got v=%b %h exp v=1 fffff00d", v, q); end
    iobus = 32'h123456F0;
    drive_req(1'b0, 1'b1, IOB + 32'h13, 32'h0, 3'b100, s0, s1, vm, v, q, iw);
    tests++; if (q !== 32'h000000F0 || s0 !== 1'b0) begin fails++; $display("FAIL io_lbu got %h stall=%b exp 000000f0 0", q, s0); end
  endtask

  task automatic test_illegal();
    drive_req(1'b0, 1'b1, 32'h100, 32'h0, 3'b011, s0, s1, vm, v, q, iw);
    tests++; if (v !== 1'b1 || q !== 32'h0) begin fails++; $display("FAIL illegal_load got v=%b %h exp v=1 00000000", v, q); end
    drive_req(1'b1, 1'b0, 32'h100, 32'hFFFFFFFF, 3'b110, s0, s1, vm, v, q, iw);
    drive_req(1'b0, 1'b1, 32'h100, 32'h0, 3'b010, s0, s1, vm, v, q, iw);
    tests++; if (q !== model_load(32'h100, 3'b010, 32'h0)) begin fails++; $display("FAIL illegal_store_nowrite got %h exp %h", q, model_load(32'h100, 3'b010, 32'h0)); end
  endtask

  task automatic test_wrap();
    store(32'hFFFC, 32'h01020304, 3'b010);
    store(32'hFFFF, 32'h0000005A, 3'b000);
    store(32'h0000, 32'h000000A5, 3'b000);
    drive_req(1'b0, 1'b1, 32'hFFFF, 32'h0, 3'b001, s0, s1, vm, v, q, iw);
    tests++; if (s0 !== 1'b1 || q !== 32'hFFFFA55A) begin fails++; $display("FAIL wrap_lh got %h stall=%b exp ffffa55a 1", q, s0); end
    drive_req(1'b0, 1'b1, 32'hFFFD, 32'h0, 3'b010, s0, s1, vm, v, q, iw);
    tests++; if (q !== model_load(32'hFFFD, 3'b010, 32'h0)) begin fails++; $display("FAIL wrap_lw got %h exp %h", q, model_load(32'hFFFD, 3'b010, 32'h0)); end
  endtask

  task automatic test_reset_in_split();
    @(negedge clk);
    rd = 1'b1; addr = 32'hFFFF; size = 3'b001;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0;
    tests++; if (valid !== 1'b0 || dout !== 32'h0) begin fails++; $display("FAIL reset_split_load got v=%b %h exp v=0 00000000", valid, dout); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    tests++; if (valid !== 1'b0 || stall !== 1'b0) begin fails++; $display("FAIL reset_split_idle got v=%b stall=%b exp 0 0", valid, stall); end
    store(32'h3F0, 32'h0, 3'b010);
    store(32'h3F4, 32'h0, 3'b010);
    @(negedge clk);
    we = 1'b1; addr = 32'h3F1; din = 32'hA1B2C3D4; size = 3'b010;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
    model_store(32'h3F1, 32'hA1B2C3D4, 3'b010, 3);
    @(negedge clk); rst = 1'b0;
    drive_req(1'b0, 1'b1, 32'h3F0, 32'h0, 3'b010, s0, s1, vm, v, q, iw);
    tests++; if (q !== 32'hB2C3D400) begin fails++; $display("FAIL reset_split_first got %h exp b2c3d400", q); end
    drive_req(1'b0, 1'b1, 32'h3F4, 32'h0, 3'b010, s0, s1, vm, v, q, iw);
    tests++; if (q !== 32'h0) begin fails++; $display("FAIL reset_split_second got %h exp 00000000", q); end
  endtask

  task automatic test_random();
    logic [31:0] a, d, exp;
    logic [2:0]  s;
    logic        w, r;
    int          op;
    logic [2:0]  legal_sz [5];
    legal_sz = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < 18; i++) store(32'(4 * i), $urandom, 3'b010);
    for (int k = 0; k < 200; k++) begin
      a  = ($urandom_range(0, 9) == 0) ? IOB + 32'($urandom_range(0, 255)) : 32'($urandom_range(0, 63));
      s  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : legal_sz[$urandom_range(0, 4)];
      d  = $urandom;
      iobus = $urandom;
      op = $urandom_range(0, 4);
      w  = (op == 0 || op == 3);
      r  = (op != 0);
      exp = model_load(a, s, iobus);
      drive_req(w, r, a, d, s, s0, s1, vm, v, q, iw);
      tests++; if (s0 !== 1'(will_split(a, s))) begin fails++; $display("FAIL rnd_stall a=%h s=%0d got %b exp %b", a, s, s0, will_split(a, s)); end
      tests++; if (iw !== (w && a >= IOB && nbytes_of(s) != 0)) begin fails++; $display("FAIL rnd_io_wr a=%h got %b", a, iw); end
      if (w) begin
        model_store(a, d, s, 4);
        tests++; if (v !== 1'b0) begin fails++; $display("FAIL rnd_store_valid a=%h got %b exp 0", a, v); end
      end else begin
        tests++; if (v !== 1'b1 || q !== exp) begin fails++; $display("FAIL rnd_load a=%h s=%0d got v=%b %h exp v=1 %h", a, s, v, q, exp); end
        if (s0) begin
          tests++; if (vm !== 1'b0) begin fails++; $display("FAIL rnd_split_valid_early a=%h got %b", a, vm); end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; rd = 1'b0; addr = 32'h0; din = 32'h0; size = 3'b010; iobus = 32'h0;
    for (int i = 0; i < NBYTES; i++) model[i] = 8'h0;
    test_reset();
    test_word();
    test_byte();
    test_split();
    test_io();
    test_illegal();
    test_wrap();
    test_reset_in_split();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
